alu_seq_hs: RTL and testbench

//  Parametrised, registered ALU with valid/ready handshakes on input and output,

---
 rtl/alu_seq_hs_if.sv | 31 +++
 rtl/alu_seq_hs.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_hs.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_hs_if.sv
// Operand/result handshake bundle for alu_seq_hs. The slave side is the ALU.
// The master side is the operand source and result consumer.
interface alu_seq_hs_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, result_hi,
        output flag_z, flag_c, flag_v, flag_n
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  flag_z, flag_c, flag_v, flag_n
    );
endinterface

// File: rtl/alu_seq_hs.sv
// Registered WIDTH-bit ALU with flags and a 1 bit/cycle shift-add MUL; latency is 1 cycle, or WIDTH+1 for MUL.
// in_ready is high only in IDLE. A result is held stable until out_ready, so the peak rate is one op per two cycles.
module alu_seq_hs #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_seq_hs_if.slave  i_bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_z, r_c, r_v, r_n;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [SHW-1:0]     w_amt;
    logic [2*WIDTH-1:0] w_shl;
    logic [2*WIDTH-1:0] w_shr;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [WIDTH:0]     w_psum;
    logic [WIDTH-1:0]   w_hi_nx;
    logic [WIDTH-1:0]   w_lo_nx;

    assign w_add = {1'b0, i_bus.a} + {1'b0, i_bus.b};
    assign w_sub = {1'b0, i_bus.a} - {1'b0, i_bus.b};
    assign w_amt = i_bus.b[SHW-1:0];
    // Widened shifts: the bit adjacent to the kept half is the last one shifted out.
    assign w_shl = {{WIDTH{1'b0}}, i_bus.a} << w_amt;
    assign w_shr = {i_bus.a, {WIDTH{1'b0}}} >> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_bus.op)
            OP_ADD: begin
                w_res = w_add[WIDTH-1:0];
                w_c   = w_add[WIDTH];
                w_v   = (i_bus.a[WIDTH-1] == i_bus.b[WIDTH-1]) &&
                        (w_add[WIDTH-1] != i_bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_sub[WIDTH-1:0];
                w_c   = w_sub[WIDTH];
                w_v   = (i_bus.a[WIDTH-1] != i_bus.b[WIDTH-1]) &&
                        (w_sub[WIDTH-1] != i_bus.a[WIDTH-1]);
            end
            OP_AND: w_res = i_bus.a & i_bus.b;
            OP_OR:  w_res = i_bus.a | i_bus.b;
            OP_XOR: w_res = i_bus.a ^ i_bus.b;
            OP_SHL: begin
                w_res = w_shl[WIDTH-1:0];
                w_c   = w_shl[WIDTH];
            end
            OP_SHR: begin
                w_res = w_shr[2*WIDTH-1:WIDTH];
                w_c   = w_shr[WIDTH-1];
            end
            default: ;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift the accumulator right.
    assign w_psum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_hi_nx = w_psum[WIDTH:1];
    assign w_lo_nx = {w_psum[0], r_acc_lo[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_n         <= 1'b0;
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        if (i_bus.op == OP_MUL) begin
                            r_mcand  <= i_bus.a;
                            r_acc_hi <= '0;
                            r_acc_lo <= i_bus.b;
                            r_cnt    <= '0;
                            r_state  <= S_MUL;
                        end else begin
                            r_result    <= w_res;
                            r_result_hi <= '0;
                            r_z         <= (w_res == '0);
                            r_c         <= w_c;
                            r_v         <= w_v;
                            r_n         <= w_res[WIDTH-1];
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    r_acc_hi <= w_hi_nx;
                    r_acc_lo <= w_lo_nx;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_result    <= w_lo_nx;
                        r_result_hi <= w_hi_nx;
                        r_z         <= ({w_hi_nx, w_lo_nx} == '0);
                        r_c         <= |w_hi_nx;
                        r_v         <= 1'b0;
                        r_n         <= w_hi_nx[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign i_bus.in_ready  = r_in_ready;
    assign i_bus.out_valid = r_out_valid;
    assign i_bus.result    = r_result;
    assign i_bus.result_hi = r_result_hi;
    assign i_bus.flag_z    = r_z;
    assign i_bus.flag_c    = r_c;
    assign i_bus.flag_v    = r_v;
    assign i_bus.flag_n    = r_n;
endmodule

// File: tb/tb_alu_seq_hs.sv
// Scoreboard bench for alu_seq_hs at WIDTH=8: directed op tables, reset aborts, back-pressure, random traffic.
module tb_alu_seq_hs;
    localparam int W = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
    localparam logic [2:0] XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       z, c, v, n;
    } res_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        res_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_hs_if #(.WIDTH(W)) bus ();
    alu_seq_hs #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .i_bus(bus));

    res_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic res_t obs();
        res_t r;
        r.res = bus.result; r.hi = bus.result_hi;
        r.z = bus.flag_z; r.c = bus.flag_c; r.v = bus.flag_v; r.n = bus.flag_n;
        return r;
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("res=%h hi=%h z=%b c=%b v=%b n=%b", r.res, r.hi, r.z, r.c, r.v, r.n);
    endfunction

    function automatic vec_t mkv(logic [2:0] op, int a, int b, int r, int h,
                                 bit z, bit c, bit v, bit n);
        vec_t t;
        t.op = op; t.a = 8'(a); t.b = 8'(b);
        t.exp.res = 8'(r); t.exp.hi = 8'(h);
        t.exp.z = z; t.exp.c = c; t.exp.v = v; t.exp.n = n;
        return t;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic res_t model(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        res_t r;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sbv = int'($signed(b));
        int amt = ub % 8;
        int t = 0;
        r = '0;
        case (op)
            ADD: begin
                t = ua + ub; r.res = t[7:0]; r.c = (t > 255);
                r.v = (sa + sbv > 127) || (sa + sbv < -128);
            end
            SUB: begin
                t = ua - ub; r.res = t[7:0]; r.c = (ua < ub);
                r.v = (sa - sbv > 127) || (sa - sbv < -128);
            end
            AND_: r.res = a & b;
            OR_:  r.res = a | b;
            XOR_: r.res = a ^ b;
            SHL: begin
                t = ua << amt; r.res = t[7:0];
                r.c = (amt != 0) && a[8 - amt];
            end
            SHR: begin
                r.res = a >> amt;
                r.c = (amt != 0) && a[amt - 1];
            end
            default: begin
                t = ua * ub; r.res = t[7:0]; r.hi = t[15:8];
                r.c = (t[15:8] != 0);
            end
        endcase
        r.z = (op == MUL) ? (t == 0) : (r.res == 0);
        r.n = (op == MUL) ? r.hi[7] : r.res[7];
        return r;
    endfunction

    // Present one op and hold it until accepted; returns at the negedge after the accept edge.
    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk); n++;
        end
        if (!bus.in_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout in_ready=%b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic exec(input vec_t v, output res_t o, output int lat);
        sb.push_back(v.exp);
        drive(v.op, v.a, v.b);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk); lat++;
        end
        if (!bus.out_valid) begin
            vectors++; miscompares++;
            $display("FAIL result_timeout out_valid=%b required 1", bus.out_valid);
        end
        o = obs();
        if (bus.out_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs() !== '0) begin
            miscompares++;
            $display("FAIL reset_held in_ready=%b out_valid=%b %s required in_ready=1 out_valid=0 all 0",
                     bus.in_ready, bus.out_valid, fmt(obs()));
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || obs() !== '0) begin
            miscompares++;
            $display("FAIL reset_released in_ready=%b out_valid=%b %s required in_ready=1 out_valid=0 all 0",
                     bus.in_ready, bus.out_valid, fmt(obs()));
        end
    endtask

    task automatic test_reset_mid_op();
        res_t o, e;
        int   lat;
        bit   seen = 0;
        int   n = 0;
        drive(MUL, 8'd255, 8'd255);
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_busy in_ready=%b out_valid=%b required 0 0", bus.in_ready, bus.out_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs() !== '0) begin
            miscompares++;
            $display("FAIL mul_abort out_valid=%b in_ready=%b %s required 0 1 all 0",
                     bus.out_valid, bus.in_ready, fmt(obs()));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL mul_abort_phantom out_valid seen=%0d required 0", seen);
        end
        exec(mkv(ADD, 1, 1, 2, 0, 0, 0, 0, 0), o, lat);
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL post_abort_add got %s required %s", fmt(o), fmt(e));
        end
        // Reset while a finished result is waiting for the consumer.
        bus.out_ready = 1'b0;
        drive(ADD, 8'd200, 8'd100);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk); n++;
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== 8'd44) begin
            miscompares++;
            $display("FAIL done_before_reset out_valid=%b result=%0d required 1 44",
                     bus.out_valid, bus.result);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs() !== '0) begin
            miscompares++;
            $display("FAIL done_abort out_valid=%b in_ready=%b %s required 0 1 all 0",
                     bus.out_valid, bus.in_ready, fmt(obs()));
        end
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        vec_t t[$];
        res_t o, e;
        int   lat;
        t.push_back(mkv(ADD, 200, 100,  44, 0, 0, 1, 0, 0));
        t.push_back(mkv(ADD, 127,   1, 128, 0, 0, 0, 1, 1));
        t.push_back(mkv(SUB,   5,   5,   0, 0, 1, 0, 0, 0));
        t.push_back(mkv(SUB,   3,   4, 255, 0, 0, 1, 0, 1));
        t.push_back(mkv(SUB, 128,   1, 127, 0, 0, 0, 1, 0));
        foreach (t[i]) begin
            exec(t[i], o, lat);
            e = sb.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL arith[%0d] got %s required %s", i, fmt(o), fmt(e));
            end
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL arith_latency[%0d] got %0d required 1", i, lat);
            end
        end
    endtask

    task automatic test_mul();
        vec_t t[$];
        res_t o, e;
        int   lat;
        t.push_back(mkv(MUL, 255, 255,   1, 254, 0, 1, 0, 1));
        t.push_back(mkv(MUL,   0,  77,   0,   0, 1, 0, 0, 0));
        t.push_back(mkv(MUL,  13,  11, 143,   0, 0, 0, 0, 0));
        t.push_back(mkv(MUL, 128,   2,   0,   1, 0, 1, 0, 0));
        foreach (t[i]) begin
            exec(t[i], o, lat);
            e = sb.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mul[%0d] got %s required %s", i, fmt(o), fmt(e));
            end
            vectors++;
            if (lat !== 9) begin
                miscompares++;
                $display("FAIL mul_latency[%0d] got %0d required 9", i, lat);
            end
        end
    endtask

    task automatic test_shift_logic();
        vec_t t[$];
        res_t o, e;
        int   lat;
        t.push_back(mkv(SHL,  'h81, 1, 'h02, 0, 0, 1, 0, 0));
        t.push_back(mkv(SHR,  'h81, 1, 'h40, 0, 0, 1, 0, 0));
        t.push_back(mkv(SHL,  'h81, 8, 'h81, 0, 0, 0, 0, 1));
        t.push_back(mkv(SHR,  'h81, 7, 'h01, 0, 0, 0, 0, 0));
        t.push_back(mkv(SHL,  'h03, 7, 'h80, 0, 0, 1, 0, 1));
        t.push_back(mkv(AND_, 'hF0, 'h3C, 'h30, 0, 0, 0, 0, 0));
        t.push_back(mkv(OR_,  'hF0, 'h3C, 'hFC, 0, 0, 0, 0, 1));
        t.push_back(mkv(XOR_, 'hF0, 'h3C, 'hCC, 0, 0, 0, 0, 1));
        t.push_back(mkv(XOR_, 'h5A, 'h5A, 'h00, 0, 1, 0, 0, 0));
        foreach (t[i]) begin
            exec(t[i], o, lat);
            e = sb.pop_front();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL shift_logic[%0d] got %s required %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_back_pressure();
        res_t e;
        int   n = 0;
        bus.out_ready = 1'b0;
        sb.push_back(mkv(ADD, 1, 2, 3, 0, 0, 0, 0, 0).exp);
        drive(ADD, 8'd1, 8'd2);
        while (!bus.out_valid && n < 20) begin
            @(negedge clk); n++;
        end
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || obs() !== e) begin
            miscompares++;
            $display("FAIL bp_result out_valid=%b got %s required 1 %s", bus.out_valid, fmt(obs()), fmt(e));
        end
        for (int i = 0; i < 5; i++) begin
            bus.op = ADD; bus.a = 8'd9; bus.b = 8'd9; bus.in_valid = 1'b1;
            @(negedge clk);
            vectors++;
            if (obs() !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] out_valid=%b in_ready=%b got %s required 1 0 %s",
                         i, bus.out_valid, bus.in_ready, fmt(obs()), fmt(e));
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        localparam int N = 200;
        fork
            begin
                int sent = 0;
                int cyc = 0;
                bit acc = 0;
                while (sent < N && cyc < 20000) begin
                    @(negedge clk); cyc++;
                    if (acc) begin bus.in_valid = 1'b0; acc = 0; end
                    if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
                        bus.op = 3'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
                        bus.in_valid = 1'b1;
                    end
                    if (bus.in_valid && bus.in_ready) begin
                        sb.push_back(model(bus.op, bus.a, bus.b));
                        sent++; acc = 1;
                    end
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin
                int   got = 0;
                int   cyc = 0;
                res_t o, e;
                while (got < N && cyc < 20000) begin
                    @(negedge clk); cyc++;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        o = obs();
                        vectors++;
                        if (sb.size() == 0) begin
                            miscompares++;
                            $display("FAIL rand_unexpected got %s required no result", fmt(o));
                        end else begin
                            e = sb.pop_front();
                            if (o !== e) begin
                                miscompares++;
                                $display("FAIL rand[%0d] got %s required %s", got, fmt(o), fmt(e));
                            end
                        end
                        got++;
                    end
                end
                vectors++;
                if (got != N) begin
                    miscompares++;
                    $display("FAIL rand_count got %0d results required %0d", got, N);
                end
            end
        join
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain pending=%0d out_valid=%b required 0 0", sb.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_arith();
        test_mul();
        test_shift_logic();
        test_back_pressure();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
